// File: rtl/board_wr_arbiter.sv
// Two-requester arbiter for the board cell RAM write port: round-robin on ties,
// bursts held up to MAX_HOLD beats while the other side waits, registered write.
module board_wr_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                last_a_q, last_a_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    last_a_d = last_a_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        // On a tie the side that did not own the port last time wins.
        if (req_a && (!req_b || !last_a_q)) state_d = GNT_A;
        else if (req_b)                     state_d = GNT_B;
      end
      GNT_A: begin
        if (req_a) begin
          we_d   = 1'b1;
          addr_d = addr_a;
          data_d = data_a;
        end
        if (!req_a)                          state_d = req_b ? GNT_B : IDLE;
        else if (req_b && hold_q == HOLD_LAST) state_d = GNT_B;
        else if (hold_q != HOLD_LAST)        hold_d = hold_q + 1'b1;
      end
      GNT_B: begin
        if (req_b) begin
          we_d   = 1'b1;
          addr_d = addr_b;
          data_d = data_b;
        end
        if (!req_b)                          state_d = req_a ? GNT_A : IDLE;
        else if (req_a && hold_q == HOLD_LAST) state_d = GNT_A;
        else if (hold_q != HOLD_LAST)        hold_d = hold_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Every fresh grant restarts the burst count and records the new owner.
    if (state_d != state_q && state_d != IDLE) begin
      hold_d   = '0;
      last_a_d = (state_d == GNT_A);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      last_a_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      last_a_q <= last_a_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign gnt_a    = (state_q == GNT_A);
  assign gnt_b    = (state_q == GNT_B);
  assign sel      = (state_q == GNT_A);
  assign busy     = (state_q != IDLE);
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;

endmodule

// File: tb/tb_board_wr_arbiter.sv
// Bench for board_wr_arbiter: directed scenarios plus a long random run, all checked
// cycle by cycle against an ownership/run-length model of the arbitration rules.
module tb_board_wr_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 2;
  localparam int MAX_HOLD = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_a, req_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              gnt_a, gnt_b, sel, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  board_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: who owns the port (0 none, 1 A, 2 B), how many cycles the current
  // owner has held it, who was granted most recently, and the expected write.
  int                m_owner, m_run, m_last;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] wr_log[$];

  task automatic model_edge();
    int nxt, other;
    bit own, oth;
    if (!rst_n) begin
      m_owner = 0; m_run = 0; m_last = 2;
      m_we = 0; m_addr = '0; m_data = '0;
      return;
    end
    m_we = 0;
    if (m_owner == 1 && req_a) begin m_we = 1; m_addr = addr_a; m_data = data_a; end
    if (m_owner == 2 && req_b) begin m_we = 1; m_addr = addr_b; m_data = data_b; end
    if (m_owner == 0) begin
      if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
      else if (req_a)     nxt = 1;
      else if (req_b)     nxt = 2;
      else                nxt = 0;
    end else begin
      other = 3 - m_owner;
      own   = (m_owner == 1) ? req_a : req_b;
      oth   = (m_owner == 1) ? req_b : req_a;
      if (!own)                           nxt = oth ? other : 0;
      else if (oth && m_run + 1 >= MAX_HOLD) nxt = other;
      else                                nxt = m_owner;
    end
    if (nxt != 0 && nxt == m_owner) m_run++;
    else if (nxt != 0) begin m_run = 0; m_last = nxt; end
    m_owner = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("gnt_a",    32'(gnt_a),    32'(m_owner == 1));
    check_eq("gnt_b",    32'(gnt_b),    32'(m_owner == 2));
    check_eq("sel",      32'(sel),      32'(m_owner == 1));
    check_eq("busy",     32'(busy),     32'(m_owner != 0));
    check_eq("onehot",   32'(gnt_a & gnt_b), 32'd0);
    check_eq("mem_we",   32'(mem_we),   32'(m_we));
    check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
    check_eq("mem_data", 32'(mem_data), 32'(m_data));
    if (mem_we) wr_log.push_back(mem_addr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_a = 0; req_b = 0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_b, cnt_w, wait_a, wait_b;
    rst_n = 0; req_a = 0; req_b = 0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;

    // Reset state
    do_reset();
    check_eq("rst_state", {gnt_a, gnt_b, sel, mem_we, busy, 32'(mem_addr), 32'(mem_data)} != 0, 0);

    // 1: single A burst 5,6,7
    wr_log.delete();
    req_a = 1; addr_a = 10'd5; data_a = 2'd1;
    tick(); check_eq("t1_gnt_rise", 32'(gnt_a), 1); check_eq("t1_no_early_we", 32'(mem_we), 0);
    tick(); addr_a = 10'd6;
    tick(); addr_a = 10'd7;
    tick(); req_a = 0;
    tick(); tick();
    check_eq("t1_nwrites", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check_eq("t1_w0", 32'(wr_log[0]), 5);
      check_eq("t1_w1", 32'(wr_log[1]), 6);
      check_eq("t1_w2", 32'(wr_log[2]), 7);
    end
    $display("t1 single A burst: %0d writes", wr_log.size());

    // 2: both requesting from reset, round-robin with MAX_HOLD cap
    do_reset();
    req_a = 1; req_b = 1;
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (t == 1)  check_eq("t2_a_first", 32'(gnt_a), 1);
      if (t == 8)  check_eq("t2_a_last",  32'(gnt_a), 1);
      if (t == 9)  check_eq("t2_b_nogap", 32'(gnt_b), 1);
      if (t == 16) check_eq("t2_b_last",  32'(gnt_b), 1);
      if (t == 17) check_eq("t2_back_a",  32'(gnt_a), 1);
    end
    $display("t2 tie alternation: done at cycle 17");

    // 3: sustained B-only burst
    do_reset();
    wr_log.delete();
    req_b = 1; addr_b = 10'd100; data_b = 2'd3;
    tick();
    cnt_b = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      cnt_b += gnt_b;
      check_eq("t3_sel0", 32'(sel), 0);
    end
    req_b = 0;
    tick(); tick();
    check_eq("t3_gnt_cycles", cnt_b, 20);
    check_eq("t3_nwrites", wr_log.size(), 20);
    $display("t3 B-only burst: %0d grant cycles, %0d writes", cnt_b, wr_log.size());

    // 4: A drops mid-burst while B waits
    do_reset();
    req_a = 1; req_b = 1;
    tick(); tick(); tick();
    req_a = 0;
    tick();
    check_eq("t4_gnt_b", 32'(gnt_b), 1);
    check_eq("t4_sel",   32'(sel), 0);
    check_eq("t4_no_we", 32'(mem_we), 0);
    req_b = 0; tick(); tick();
    $display("t4 A drop handoff: done");

    // 5: reset in the middle of an A burst
    do_reset();
    req_a = 1; addr_a = 10'd42;
    tick(); tick(); tick();
    rst_n = 0;
    tick();
    check_eq("t5_rst_we",   32'(mem_we), 0);
    check_eq("t5_rst_gnt",  32'({gnt_a, gnt_b, busy}), 0);
    check_eq("t5_rst_addr", 32'(mem_addr), 0);
    rst_n = 1; req_a = 1; req_b = 1;
    tick();
    check_eq("t5_tie_a", 32'(gnt_a), 1);
    check_eq("t5_no_we_after", 32'(mem_we), 0);
    $display("t5 mid-burst reset: done");

    // 6: random traffic with fairness bound
    do_reset();
    wait_a = 0; wait_b = 0; cnt_w = 0;
    for (int t = 0; t < 10000; t++) begin
      rst_n  = ($urandom_range(0, 499) != 0);
      req_a  = ($urandom_range(0, 99) < 70);
      req_b  = ($urandom_range(0, 99) < 60);
      addr_a = ADDR_W'($urandom_range(0, 767));
      addr_b = ADDR_W'($urandom_range(0, 767));
      data_a = DATA_W'($urandom);
      data_b = DATA_W'($urandom);
      wait_a = (rst_n && req_a && !gnt_a) ? wait_a + 1 : 0;
      wait_b = (rst_n && req_b && !gnt_b) ? wait_b + 1 : 0;
      check_eq("t6_wait_a", 32'(wait_a <= MAX_HOLD + 1), 1);
      check_eq("t6_wait_b", 32'(wait_b <= MAX_HOLD + 1), 1);
      tick();
      cnt_w += mem_we;
    end
    $display("t6 random run: 10000 cycles, %0d writes", cnt_w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
